// File: rtl/host_packet_parser.sv
// ---------------------------------------------------------------------------
// host_packet_parser
//
// Front of the DA platform datapath. Parses the 16-bit host word stream into
// packets (dest, cmd, 24-bit length, payload, 32-bit checksum) and forwards
// the payload cut-through to the command or audio stream, selected by the
// command code. At the end of each packet a one-cycle status pulse reports
// the header fields and whether the checksum matched for a known command.
//
// Handshake (all streams): a word moves on a rising clk edge when
// enable && ready are both high. The producer holds data/enable until it
// moves, and ready may depend combinationally on the consumer.
//
// Ports:
//   clk, reset                 host clock, asynchronous active-high reset
//   in_data/in_enable/in_ready host word input stream
//   cmd_data/cmd_enable/cmd_ready  command payload output stream
//   aud_data/aud_enable/aud_ready  audio payload output stream
//   cur_dest                   destination of the packet in progress
//   pkt_done                   one-cycle end-of-packet pulse
//   pkt_ok                     checksum matched and command known
//   pkt_dest/pkt_cmd/pkt_length  header fields of the finished packet
//   dbg_state                  current parser state (observability)
// ---------------------------------------------------------------------------
module host_packet_parser #(
    parameter logic [7:0] CMD_FIFO_WRITE = 8'h20,
    parameter logic [7:0] AUD_FIFO_WRITE = 8'h10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_enable,
    output logic        in_ready,
    output logic [15:0] cmd_data,
    output logic        cmd_enable,
    input  logic        cmd_ready,
    output logic [15:0] aud_data,
    output logic        aud_enable,
    input  logic        aud_ready,
    output logic [7:0]  cur_dest,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic [7:0]  pkt_dest,
    output logic [7:0]  pkt_cmd,
    output logic [23:0] pkt_length,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_DEST   = 3'd0,
        S_CMD    = 3'd1,
        S_LEN_HI = 3'd2,
        S_LEN_LO = 3'd3,
        S_DATA   = 3'd4,
        S_CK_HI  = 3'd5,
        S_CK_LO  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Header latches for the packet in progress; kept apart from the pkt_*
    // status registers so a following header cannot disturb a status pulse.
    logic [7:0]  r_dest;
    logic [7:0]  r_cmd;
    logic [7:0]  r_len_hi;
    logic [23:0] r_length;
    logic [23:0] r_count;
    logic [31:0] r_sum;
    logic [15:0] r_ck_hi;

    logic        r_pkt_done;
    logic        r_pkt_ok;
    logic [7:0]  r_pkt_dest;
    logic [7:0]  r_pkt_cmd;
    logic [23:0] r_pkt_length;

    logic        w_in_ready;
    logic        w_cmd_enable;
    logic        w_aud_enable;
    logic        w_xfer;
    logic        w_cmd_sel;
    logic        w_aud_sel;
    logic        w_known;
    logic [23:0] w_len_full;
    logic [31:0] w_ck_full;

    assign w_cmd_sel  = (r_cmd == CMD_FIFO_WRITE);
    assign w_aud_sel  = (r_cmd == AUD_FIFO_WRITE);
    assign w_known    = w_cmd_sel || w_aud_sel;
    assign w_len_full = {r_len_hi, in_data};
    assign w_ck_full  = {r_ck_hi, in_data};
    assign w_xfer     = in_enable && w_in_ready;

    // Next state and stream steering.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b1;
        w_cmd_enable = 1'b0;
        w_aud_enable = 1'b0;
        case (r_state)
            S_DEST:   if (in_enable) w_state_next = S_CMD;
            S_CMD:    if (in_enable) w_state_next = S_LEN_HI;
            S_LEN_HI: if (in_enable) w_state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (in_enable) begin
                    w_state_next = (w_len_full == 24'd0) ? S_CK_HI : S_DATA;
                end
            end
            S_DATA: begin
                // Unknown commands drain at full rate with both enables low.
                if (w_cmd_sel) begin
                    w_cmd_enable = in_enable;
                    w_in_ready   = cmd_ready;
                end else if (w_aud_sel) begin
                    w_aud_enable = in_enable;
                    w_in_ready   = aud_ready;
                end
                // r_count holds the words still to come, so 1 means this is the last.
                if (in_enable && w_in_ready && (r_count == 24'd1)) begin
                    w_state_next = S_CK_HI;
                end
            end
            S_CK_HI:  if (in_enable) w_state_next = S_CK_LO;
            S_CK_LO:  if (in_enable) w_state_next = S_DEST;
            default:  w_state_next = S_DEST;
        endcase
        if (reset) begin
            w_in_ready   = 1'b0;
            w_cmd_enable = 1'b0;
            w_aud_enable = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_DEST;
            r_dest       <= 8'd0;
            r_cmd        <= 8'd0;
            r_len_hi     <= 8'd0;
            r_length     <= 24'd0;
            r_count      <= 24'd0;
            r_sum        <= 32'd0;
            r_ck_hi      <= 16'd0;
            r_pkt_done   <= 1'b0;
            r_pkt_ok     <= 1'b0;
            r_pkt_dest   <= 8'd0;
            r_pkt_cmd    <= 8'd0;
            r_pkt_length <= 24'd0;
        end else begin
            r_state    <= w_state_next;
            r_pkt_done <= 1'b0;
            if (r_state == S_DEST) begin
                r_sum <= 32'd0;
            end
            if (w_xfer) begin
                case (r_state)
                    S_DEST:   r_dest   <= in_data[7:0];
                    S_CMD:    r_cmd    <= in_data[7:0];
                    S_LEN_HI: r_len_hi <= in_data[7:0];
                    S_LEN_LO: begin
                        r_length <= w_len_full;
                        r_count  <= w_len_full;
                    end
                    S_DATA: begin
                        r_sum   <= r_sum + {16'd0, in_data};
                        r_count <= r_count - 24'd1;
                    end
                    S_CK_HI:  r_ck_hi <= in_data;
                    S_CK_LO: begin
                        r_pkt_done   <= 1'b1;
                        r_pkt_ok     <= (w_ck_full == r_sum) && w_known;
                        r_pkt_dest   <= r_dest;
                        r_pkt_cmd    <= r_cmd;
                        r_pkt_length <= r_length;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign cmd_data   = in_data;
    assign cmd_enable = w_cmd_enable;
    assign aud_data   = in_data;
    assign aud_enable = w_aud_enable;
    assign cur_dest   = r_dest;
    assign pkt_done   = r_pkt_done;
    assign pkt_ok     = r_pkt_ok;
    assign pkt_dest   = r_pkt_dest;
    assign pkt_cmd    = r_pkt_cmd;
    assign pkt_length = r_pkt_length;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_host_packet_parser.sv
module tb_host_packet_parser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = 16'd0;
    logic        in_enable = 1'b0;
    logic        in_ready;
    logic [15:0] cmd_data;
    logic        cmd_enable;
    logic        cmd_ready = 1'b1;
    logic [15:0] aud_data;
    logic        aud_enable;
    logic        aud_ready = 1'b1;
    logic [7:0]  cur_dest;
    logic        pkt_done;
    logic        pkt_ok;
    logic [7:0]  pkt_dest;
    logic [7:0]  pkt_cmd;
    logic [23:0] pkt_length;
    logic [2:0]  dbg_state;

    int checks = 0;
    int failures = 0;

    logic [15:0] cmd_exp_q[$];
    logic [15:0] aud_exp_q[$];
    logic [40:0] pkt_exp_q[$];   // {ok, dest, cmd, length}

    int cmd_seen = 0;
    int aud_seen = 0;
    int stall_cycles = 0;
    bit rand_ready = 1'b0;

    host_packet_parser dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_enable  (in_enable),
        .in_ready   (in_ready),
        .cmd_data   (cmd_data),
        .cmd_enable (cmd_enable),
        .cmd_ready  (cmd_ready),
        .aud_data   (aud_data),
        .aud_enable (aud_enable),
        .aud_ready  (aud_ready),
        .cur_dest   (cur_dest),
        .pkt_done   (pkt_done),
        .pkt_ok     (pkt_ok),
        .pkt_dest   (pkt_dest),
        .pkt_cmd    (pkt_cmd),
        .pkt_length (pkt_length),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Random downstream readiness, only while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                cmd_ready = ($urandom_range(0, 3) != 0);
                aud_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // ---------------- scoreboard ----------------
    initial begin
        logic [15:0] e16;
        logic [40:0] e41;
        forever begin
            @(negedge clk);
            if (cmd_enable === 1'b1) begin
                if (cmd_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cmd_unexpected got=%h required=none", cmd_data);
                end else if (cmd_ready) begin
                    e16 = cmd_exp_q.pop_front();
                    checks++; cmd_seen++;
                    if (cmd_data !== e16) begin
                        failures++;
                        $display("FAIL cmd_data got=%h required=%h", cmd_data, e16);
                    end
                end
            end
            if (aud_enable === 1'b1) begin
                if (aud_exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL aud_unexpected got=%h required=none", aud_data);
                end else if (aud_ready) begin
                    e16 = aud_exp_q.pop_front();
                    checks++; aud_seen++;
                    if (aud_data !== e16) begin
                        failures++;
                        $display("FAIL aud_data got=%h required=%h", aud_data, e16);
                    end
                end
            end
            if (pkt_done !== 1'b0) begin
                checks++;
                if (pkt_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pkt_unexpected got ok=%b dest=%h cmd=%h len=%h required=no pulse",
                             pkt_ok, pkt_dest, pkt_cmd, pkt_length);
                end else begin
                    e41 = pkt_exp_q.pop_front();
                    if ({pkt_ok, pkt_dest, pkt_cmd, pkt_length} !== e41) begin
                        failures++;
                        $display("FAIL pkt_status got ok=%b dest=%h cmd=%h len=%h required ok=%b dest=%h cmd=%h len=%h",
                                 pkt_ok, pkt_dest, pkt_cmd, pkt_length,
                                 e41[40], e41[39:32], e41[31:24], e41[23:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one word and returns #1 after the edge that accepted it.
    task automatic send_word(input logic [15:0] w);
        bit done = 1'b0;
        in_data   = w;
        in_enable = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) done = 1'b1;
            else stall_cycles++;
            @(posedge clk);
            #1;
        end
        in_enable = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL send_word_timeout got=no accept required=accept word %h", w);
        end
    endtask

    // Reference model plus stimulus for one packet. stop_after >= 0 abandons
    // the packet after that many payload words (no status expected).
    task automatic send_packet(input logic [7:0] dest, input logic [7:0] cmd,
                               input logic [15:0] pl[$], input logic [31:0] ck,
                               input bit gaps, input int stop_after = -1);
        logic [31:0] sum = 32'd0;
        logic [23:0] len;
        bit          known;
        bit          ok;
        len   = 24'(pl.size());
        known = (cmd == 8'h20) || (cmd == 8'h10);
        foreach (pl[i]) sum = sum + {16'd0, pl[i]};
        ok = (sum == ck) && known;
        foreach (pl[i]) begin
            if (stop_after < 0 || i < stop_after) begin
                if (cmd == 8'h20) cmd_exp_q.push_back(pl[i]);
                if (cmd == 8'h10) aud_exp_q.push_back(pl[i]);
            end
        end
        if (stop_after < 0) pkt_exp_q.push_back({ok, dest, cmd, len});

        // Upper byte of byte-sized header words is noise that must be ignored.
        send_word({8'($urandom), dest});
        if (gaps && $urandom_range(0, 3) == 0) idle(1);
        send_word({8'($urandom), cmd});
        send_word({8'($urandom), len[23:16]});
        send_word(len[15:0]);
        foreach (pl[i]) begin
            if (stop_after >= 0 && i >= stop_after) return;
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_word(pl[i]);
        end
        if (stop_after >= 0) return;
        send_word(ck[31:16]);
        if (gaps && $urandom_range(0, 3) == 0) idle(1);
        send_word(ck[15:0]);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100; k++) begin
            if (pkt_exp_q.size() == 0 && cmd_exp_q.size() == 0 && aud_exp_q.size() == 0) break;
            idle(1);
        end
        idle(2);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        in_enable = 1'b1;
        in_data = 16'hFFFF;
        idle(2);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b required=0", in_ready); end
        checks++; if (cmd_enable !== 1'b0) begin failures++; $display("FAIL reset_cmd_enable got=%b required=0", cmd_enable); end
        checks++; if (aud_enable !== 1'b0) begin failures++; $display("FAIL reset_aud_enable got=%b required=0", aud_enable); end
        checks++; if (pkt_done !== 1'b0) begin failures++; $display("FAIL reset_pkt_done got=%b required=0", pkt_done); end
        checks++; if (pkt_ok !== 1'b0) begin failures++; $display("FAIL reset_pkt_ok got=%b required=0", pkt_ok); end
        checks++; if (cur_dest !== 8'h00) begin failures++; $display("FAIL reset_cur_dest got=%h required=00", cur_dest); end
        checks++; if ({pkt_dest, pkt_cmd, pkt_length} !== 40'd0) begin
            failures++; $display("FAIL reset_pkt_fields got=%h required=0", {pkt_dest, pkt_cmd, pkt_length});
        end
        in_enable = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_cmd_packet();
        logic [15:0] pl[$];
        int c0, a0;
        rand_ready = 1'b0; cmd_ready = 1'b1; aud_ready = 1'b1;
        c0 = cmd_seen; a0 = aud_seen;
        pl = {16'h0060, 16'h0029, 16'h00A3};
        send_packet(8'h01, 8'h20, pl, 32'h0000_012C, 1'b0);
        wait_drain();
        checks++; if (pkt_exp_q.size() != 0) begin failures++; $display("FAIL cmd_pkt_status_missing got=%0d pending required=0", pkt_exp_q.size()); end
        checks++; if (cmd_seen - c0 != 3) begin failures++; $display("FAIL cmd_pkt_count got=%0d required=3", cmd_seen - c0); end
        checks++; if (aud_seen - a0 != 0) begin failures++; $display("FAIL cmd_pkt_aud_count got=%0d required=0", aud_seen - a0); end
        checks++; if (cur_dest !== 8'h01) begin failures++; $display("FAIL cmd_pkt_cur_dest got=%h required=01", cur_dest); end
    endtask

    task automatic test_aud_packet();
        logic [15:0] pl[$];
        int a0;
        a0 = aud_seen;
        for (int i = 0; i < 10; i++) pl.push_back(16'((2 * i) | ((2 * i + 1) << 8)));
        send_packet(8'h01, 8'h10, pl, 32'h0000_645A, 1'b0);
        wait_drain();
        checks++; if (aud_seen - a0 != 10) begin failures++; $display("FAIL aud_pkt_count got=%0d required=10", aud_seen - a0); end
        checks++; if (pkt_exp_q.size() != 0) begin failures++; $display("FAIL aud_pkt_status_missing got=%0d pending required=0", pkt_exp_q.size()); end
    endtask

    task automatic test_bad_checksum();
        logic [15:0] pl[$];
        int c0;
        c0 = cmd_seen;
        pl = {16'h0060, 16'h0029, 16'h00A3};
        send_packet(8'h02, 8'h20, pl, 32'h0000_012D, 1'b0);   // expected ok=0 by model
        send_packet(8'h03, 8'h20, pl, 32'h0000_012C, 1'b0);   // immediately following, ok=1
        wait_drain();
        checks++; if (cmd_seen - c0 != 6) begin failures++; $display("FAIL bad_ck_forward_count got=%0d required=6", cmd_seen - c0); end
        checks++; if (pkt_exp_q.size() != 0) begin failures++; $display("FAIL bad_ck_status_missing got=%0d pending required=0", pkt_exp_q.size()); end
    endtask

    task automatic test_zero_length();
        logic [15:0] pl[$];
        int c0, a0;
        c0 = cmd_seen; a0 = aud_seen;
        send_packet(8'h00, 8'h20, pl, 32'h0000_0000, 1'b0);
        wait_drain();
        checks++; if (cmd_seen - c0 + aud_seen - a0 != 0) begin failures++; $display("FAIL zero_len_payload got=%0d required=0", cmd_seen - c0 + aud_seen - a0); end
        checks++; if (pkt_exp_q.size() != 0) begin failures++; $display("FAIL zero_len_status_missing got=%0d pending required=0", pkt_exp_q.size()); end
        checks++; if (cur_dest !== 8'h00) begin failures++; $display("FAIL zero_len_cur_dest got=%h required=00", cur_dest); end
    endtask

    task automatic test_backpressure();
        logic [15:0] pl[$];
        logic [31:0] sum = 32'd0;
        int a0, s0, target;
        rand_ready = 1'b0; cmd_ready = 1'b1; aud_ready = 1'b1;
        a0 = aud_seen; s0 = stall_cycles; target = aud_seen + 3;
        for (int i = 0; i < 10; i++) begin
            pl.push_back(16'($urandom));
            sum = sum + {16'd0, pl[i]};
        end
        fork
            send_packet(8'h44, 8'h10, pl, sum, 1'b0);
            begin
                for (int k = 0; k < 100; k++) begin
                    if (aud_seen >= target) break;
                    idle(1);
                end
                aud_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b required=0", in_ready); end
                    @(posedge clk);
                    #1;
                end
                aud_ready = 1'b1;
            end
        join
        wait_drain();
        checks++; if (aud_seen - a0 != 10) begin failures++; $display("FAIL bp_aud_count got=%0d required=10", aud_seen - a0); end
        checks++; if (stall_cycles - s0 != 5) begin failures++; $display("FAIL bp_stalls got=%0d required=5", stall_cycles - s0); end
        checks++; if (pkt_exp_q.size() != 0) begin failures++; $display("FAIL bp_status_missing got=%0d pending required=0", pkt_exp_q.size()); end
    endtask

    task automatic test_unknown_cmd();
        logic [15:0] pl[$];
        logic [31:0] sum;
        int s0;
        rand_ready = 1'b0; cmd_ready = 1'b0; aud_ready = 1'b0;
        s0 = stall_cycles;
        pl = {16'($urandom), 16'($urandom)};
        sum = {16'd0, pl[0]} + {16'd0, pl[1]};
        send_packet(8'h55, 8'h55, pl, sum, 1'b0);   // good sum, unknown command -> ok=0
        wait_drain();
        checks++; if (stall_cycles - s0 != 0) begin failures++; $display("FAIL unknown_drain_stalls got=%0d required=0", stall_cycles - s0); end
        checks++; if (pkt_exp_q.size() != 0) begin failures++; $display("FAIL unknown_status_missing got=%0d pending required=0", pkt_exp_q.size()); end
        cmd_ready = 1'b1; aud_ready = 1'b1;
    endtask

    task automatic test_reset_mid_data();
        logic [15:0] pl[$];
        logic [31:0] sum;
        rand_ready = 1'b0; cmd_ready = 1'b1; aud_ready = 1'b1;
        pl = {16'h1111, 16'h2222, 16'h3333};
        send_packet(8'h07, 8'h20, pl, 32'h0000_6666, 1'b0, 1);
        in_data = pl[1];
        in_enable = 1'b1;
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got=%b required=0", in_ready); end
        checks++; if (cmd_enable !== 1'b0) begin failures++; $display("FAIL mid_rst_cmd_enable got=%b required=0", cmd_enable); end
        checks++; if (aud_enable !== 1'b0) begin failures++; $display("FAIL mid_rst_aud_enable got=%b required=0", aud_enable); end
        checks++; if (cur_dest !== 8'h00) begin failures++; $display("FAIL mid_rst_cur_dest got=%h required=00", cur_dest); end
        checks++; if ({pkt_done, pkt_ok} !== 2'b00) begin failures++; $display("FAIL mid_rst_status got=%b required=00", {pkt_done, pkt_ok}); end
        idle(2);
        checks++; if (cmd_exp_q.size() != 0) begin failures++; $display("FAIL mid_rst_first_word got=%0d pending required=0", cmd_exp_q.size()); end
        reset = 1'b0;
        in_enable = 1'b0;
        pl = {16'hA001, 16'hA002, 16'hA003};
        sum = 32'h0001_E006;
        send_packet(8'h09, 8'h10, pl, sum, 1'b0);
        wait_drain();
        checks++; if (pkt_exp_q.size() != 0) begin failures++; $display("FAIL mid_rst_fresh_status got=%0d pending required=0", pkt_exp_q.size()); end
        checks++; if (cur_dest !== 8'h09) begin failures++; $display("FAIL mid_rst_fresh_dest got=%h required=09", cur_dest); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pl[$];
        rand_ready = 1'b0; cmd_ready = 1'b1; aud_ready = 1'b1;
        pl = {16'hBEEF};
        send_packet(8'hB1, 8'h10, pl, 32'h0000_BEEF, 1'b0);
        pl = {};
        send_packet(8'hB2, 8'h20, pl, 32'h0000_0000, 1'b0);
        pl = {16'hFFFF, 16'hFFFF};
        send_packet(8'hB3, 8'h20, pl, 32'h0001_FFFE, 1'b0);
        wait_drain();
        checks++; if (pkt_exp_q.size() != 0) begin failures++; $display("FAIL b2b_status_missing got=%0d pending required=0", pkt_exp_q.size()); end
        checks++; if (cur_dest !== 8'hB3) begin failures++; $display("FAIL b2b_cur_dest got=%h required=b3", cur_dest); end
    endtask

    task automatic test_random();
        logic [15:0] pl[$];
        logic [31:0] sum;
        logic [7:0]  cmd;
        logic [7:0]  dest;
        int          len;
        rand_ready = 1'b1;
        for (int p = 0; p < 25; p++) begin
            pl = {};
            sum = 32'd0;
            len = $urandom_range(0, 8);
            case ($urandom_range(0, 2))
                0: cmd = 8'h20;
                1: cmd = 8'h10;
                default: cmd = 8'($urandom);
            endcase
            dest = 8'($urandom);
            for (int i = 0; i < len; i++) begin
                pl.push_back(16'($urandom));
                sum = sum + {16'd0, pl[i]};
            end
            if ($urandom_range(0, 3) == 0) sum = sum ^ (32'd1 << $urandom_range(0, 31));
            send_packet(dest, cmd, pl, sum, 1'b1);
        end
        wait_drain();
        rand_ready = 1'b0;
        cmd_ready = 1'b1; aud_ready = 1'b1;
        checks++; if (pkt_exp_q.size() != 0) begin failures++; $display("FAIL rand_status_missing got=%0d pending required=0", pkt_exp_q.size()); end
        checks++; if (cmd_exp_q.size() + aud_exp_q.size() != 0) begin failures++; $display("FAIL rand_payload_missing got=%0d pending required=0", cmd_exp_q.size() + aud_exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_cmd_packet();
        test_aud_packet();
        test_bad_checksum();
        test_zero_length();
        test_backpressure();
        test_unknown_cmd();
        test_reset_mid_data();
        test_back_to_back();
        test_random();
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
